// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: one-shot dual-channel ADC capture sequencer.
// Registers the ADC pins once, waits for an immediate or threshold trigger,
// then streams {I,Q} samples into the sample RAM and counts over-range hits.
module adc_capture_ctrl #(
    parameter int unsigned DW   = 14,
    parameter int unsigned AW   = 12,
    parameter int unsigned TO_W = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DW-1:0]     adc_i,
    input  logic [DW-1:0]     adc_q,
    input  logic              adc_or_a,
    input  logic              adc_or_b,
    input  logic              arm,
    input  logic              abort,
    input  logic              trig_mode,
    input  logic [DW-2:0]     trig_level,
    input  logic [AW:0]       cap_len,
    input  logic [TO_W-1:0]   trig_timeout,
    output logic              buf_we,
    output logic [AW-1:0]     buf_addr,
    output logic [2*DW-1:0]   buf_wdata,
    output logic              busy,
    output logic              done,
    output logic              timed_out,
    output logic [15:0]       ovr_count
);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t            state;
    logic [DW-1:0]     s1_i;
    logic [DW-1:0]     s1_q;
    logic              s1_or;

    logic [AW-1:0]     len_m1;
    logic              mode_q;
    logic [DW-2:0]     level_q;
    logic [TO_W-1:0]   timeout_q;
    logic [TO_W-1:0]   to_cnt;

    logic [DW-1:0]     s1_neg;
    logic [DW-2:0]     mag;
    logic              trig_hit;
    logic [AW:0]       cap_len_m1;
    logic [AW-1:0]     len_m1_next;
    logic [TO_W-1:0]   to_cnt_inc;
    logic              to_hit;
    logic [15:0]       ovr_next;

    // Input stage: one register on all ADC pins; every decision uses these.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_i  <= '0;
            s1_q  <= '0;
            s1_or <= 1'b0;
        end else begin
            s1_i  <= adc_i;
            s1_q  <= adc_q;
            s1_or <= adc_or_a | adc_or_b;
        end
    end

    // Saturating magnitude, trigger test, length clamp, timeout and over-range increments.
    always_comb begin
        s1_neg = '0 - s1_i;
        mag    = '0;
        if (!s1_i[DW-1]) begin
            mag = s1_i[DW-2:0];
        end else if (s1_i[DW-2:0] == '0) begin
            mag = '1;
        end else begin
            mag = s1_neg[DW-2:0];
        end
        trig_hit = !mode_q || (mag >= level_q);

        cap_len_m1  = cap_len - {{AW{1'b0}}, 1'b1};
        len_m1_next = cap_len_m1[AW-1:0];
        if (cap_len == '0 || (cap_len[AW] && cap_len[AW-1:0] != '0)) begin
            len_m1_next = '1;
        end

        to_cnt_inc = to_cnt + TO_W'(1);
        to_hit     = (timeout_q != '0) && (to_cnt_inc == timeout_q);

        ovr_next = ovr_count;
        if (s1_or && ovr_count != 16'hFFFF) begin
            ovr_next = ovr_count + 16'd1;
        end
    end

    // Capture FSM with registered RAM port and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            buf_we    <= 1'b0;
            buf_addr  <= '0;
            buf_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            timed_out <= 1'b0;
            ovr_count <= '0;
            len_m1    <= '0;
            mode_q    <= 1'b0;
            level_q   <= '0;
            timeout_q <= '0;
            to_cnt    <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state    <= IDLE;
                buf_we   <= 1'b0;
                buf_addr <= '0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (arm) begin
                            state     <= ARMED;
                            busy      <= 1'b1;
                            len_m1    <= len_m1_next;
                            mode_q    <= trig_mode;
                            level_q   <= trig_level;
                            timeout_q <= trig_timeout;
                            to_cnt    <= '0;
                            ovr_count <= '0;
                            timed_out <= 1'b0;
                        end
                    end
                    ARMED: begin
                        if (trig_hit) begin
                            state     <= CAPTURE;
                            buf_we    <= 1'b1;
                            buf_addr  <= '0;
                            buf_wdata <= {s1_i, s1_q};
                            ovr_count <= ovr_next;
                        end else if (to_hit) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            timed_out <= 1'b1;
                        end else begin
                            to_cnt <= to_cnt_inc;
                        end
                    end
                    CAPTURE: begin
                        if (buf_addr == len_m1) begin
                            state  <= DONE;
                            buf_we <= 1'b0;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                        end else begin
                            buf_addr  <= buf_addr + 1'b1;
                            buf_wdata <= {s1_i, s1_q};
                            ovr_count <= ovr_next;
                        end
                    end
                    DONE: begin
                        // Address holds len-1 through DONE and only then wraps.
                        state    <= IDLE;
                        buf_addr <= '0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed testbench for adc_capture_ctrl.
module tb_adc_capture_ctrl;

    localparam int DW    = 14;
    localparam int AW    = 12;
    localparam int TO_W  = 24;
    localparam int N_LOG = 4300;

    logic            clk;
    logic            reset;
    logic [DW-1:0]   adc_i, adc_q;
    logic            adc_or_a, adc_or_b;
    logic            arm, abort, trig_mode;
    logic [DW-2:0]   trig_level;
    logic [AW:0]     cap_len;
    logic [TO_W-1:0] trig_timeout;
    logic            buf_we;
    logic [AW-1:0]   buf_addr;
    logic [2*DW-1:0] buf_wdata;
    logic            busy, done, timed_out;
    logic [15:0]     ovr_count;

    adc_capture_ctrl #(.DW(DW), .AW(AW), .TO_W(TO_W)) dut (
        .clk(clk), .reset(reset), .adc_i(adc_i), .adc_q(adc_q),
        .adc_or_a(adc_or_a), .adc_or_b(adc_or_b), .arm(arm), .abort(abort),
        .trig_mode(trig_mode), .trig_level(trig_level), .cap_len(cap_len),
        .trig_timeout(trig_timeout), .buf_we(buf_we), .buf_addr(buf_addr),
        .buf_wdata(buf_wdata), .busy(busy), .done(done), .timed_out(timed_out),
        .ovr_count(ovr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus shape: I ramps base+step*j, switching to -8192 from neg_at on.
    int g_base, g_step, g_neg_at;

    logic            we_log   [N_LOG];
    logic [AW-1:0]   addr_log [N_LOG];
    logic [2*DW-1:0] data_log [N_LOG];
    logic            done_log [N_LOG];
    logic            busy_log [N_LOG];
    logic            to_log   [N_LOG];

    function automatic logic [DW-1:0] fi(input int j);
        int v;
        v = (g_neg_at >= 0 && j >= g_neg_at) ? -8192 : g_base + g_step * j;
        return v[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] fq(input int j);
        int v;
        v = 5000 - 7 * j;
        return v[DW-1:0];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives n cycles of pins (cycle j is sampled at edge j) and logs outputs after each edge.
    task automatic run_ramp(input int n, input int abort_at, input int arm_at, input int arm2_at,
                            input int ora_lo, input int ora_hi, input int orb_lo, input int orb_hi);
        for (int j = 0; j < n; j++) begin
            adc_i    = fi(j);
            adc_q    = fq(j);
            adc_or_a = (j >= ora_lo && j <= ora_hi);
            adc_or_b = (j >= orb_lo && j <= orb_hi);
            abort    = (j == abort_at);
            arm      = (j == arm_at || j == arm2_at);
            tick;
            arm   = 1'b0;
            abort = 1'b0;
            we_log[j]   = buf_we;
            addr_log[j] = buf_addr;
            data_log[j] = buf_wdata;
            done_log[j] = done;
            busy_log[j] = busy;
            to_log[j]   = timed_out;
        end
        adc_or_a = 1'b0;
        adc_or_b = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        adc_i = 14'h1234; adc_q = 14'h0abc; adc_or_a = 1'b1; adc_or_b = 1'b1;
        arm = 1'b0; abort = 1'b0; trig_mode = 1'b0; trig_level = '0;
        cap_len = '0; trig_timeout = '0;
        tick; tick;
        n_checks++;
        if ({buf_we, buf_addr, buf_wdata, busy, done, timed_out, ovr_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: we=%0b addr=%0d wdata=%h busy=%0b done=%0b to=%0b ovr=%0d, required all zero",
                     buf_we, buf_addr, buf_wdata, busy, done, timed_out, ovr_count);
        end
        reset = 1'b0; adc_or_a = 1'b0; adc_or_b = 1'b0;
        tick;
    endtask

    task automatic test_immediate;
        int nw, nd;
        trig_mode = 1'b0; cap_len = 13'd16; trig_timeout = '0;
        g_base = 0; g_step = 3; g_neg_at = -1;
        run_ramp(20, -1, 0, -1, -1, -2, -1, -2);
        n_checks++;
        if (busy_log[0] !== 1'b1 || we_log[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL imm_armed: busy=%0b we=%0b, required busy=1 we=0", busy_log[0], we_log[0]);
        end
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (we_log[k+1] !== 1'b1 || addr_log[k+1] !== k[AW-1:0] || data_log[k+1] !== {fi(k), fq(k)}) begin
                n_fail++;
                $display("FAIL imm_write%0d: we=%0b addr=%0d data=%h, required we=1 addr=%0d data=%h",
                         k, we_log[k+1], addr_log[k+1], data_log[k+1], k, {fi(k), fq(k)});
            end
        end
        n_checks++;
        if (done_log[17] !== 1'b1 || we_log[17] !== 1'b0 || busy_log[17] !== 1'b0) begin
            n_fail++;
            $display("FAIL imm_done: done=%0b we=%0b busy=%0b, required 1 0 0", done_log[17], we_log[17], busy_log[17]);
        end
        n_checks++;
        if (done_log[18] !== 1'b0 || addr_log[18] !== '0) begin
            n_fail++;
            $display("FAIL imm_after_done: done=%0b addr=%0d, required done=0 addr=0", done_log[18], addr_log[18]);
        end
        nw = 0; nd = 0;
        for (int j = 0; j < 20; j++) begin
            nw += int'(we_log[j]);
            nd += int'(done_log[j]);
        end
        n_checks++;
        if (nw != 16 || nd != 1) begin
            n_fail++;
            $display("FAIL imm_counts: writes=%0d dones=%0d, required 16 and 1", nw, nd);
        end
    endtask

    task automatic test_threshold;
        int nw;
        trig_mode = 1'b1; trig_level = 13'd1000; cap_len = 13'd4; trig_timeout = '0;
        g_base = 0; g_step = 100; g_neg_at = -1;
        run_ramp(20, -1, 0, -1, -1, -2, -1, -2);
        nw = 0;
        for (int j = 0; j < 11; j++) nw += int'(we_log[j]);
        n_checks++;
        if (nw != 0) begin
            n_fail++;
            $display("FAIL thr_pretrigger: writes=%0d before trigger, required 0", nw);
        end
        n_checks++;
        if (we_log[11] !== 1'b1 || addr_log[11] !== '0 || data_log[11][2*DW-1:DW] !== 14'd1000) begin
            n_fail++;
            $display("FAIL thr_first: we=%0b addr=%0d I=%0d, required we=1 addr=0 I=1000",
                     we_log[11], addr_log[11], data_log[11][2*DW-1:DW]);
        end
        n_checks++;
        if (done_log[15] !== 1'b1 || we_log[15] !== 1'b0) begin
            n_fail++;
            $display("FAIL thr_done: done=%0b we=%0b, required 1 0", done_log[15], we_log[15]);
        end
    endtask

    task automatic test_saturate;
        int nw, bad;
        trig_mode = 1'b1; trig_level = 13'd8191; cap_len = 13'd0; trig_timeout = '0;
        g_base = 0; g_step = 1; g_neg_at = 3;
        run_ramp(4110, -1, 0, -1, -1, -2, -1, -2);
        n_checks++;
        if (we_log[3] !== 1'b0 || we_log[4] !== 1'b1 || data_log[4][2*DW-1:DW] !== 14'h2000) begin
            n_fail++;
            $display("FAIL sat_trigger: we3=%0b we4=%0b I=%h, required 0 1 2000",
                     we_log[3], we_log[4], data_log[4][2*DW-1:DW]);
        end
        nw = 0; bad = 0;
        for (int j = 0; j < 4110; j++) begin
            if (we_log[j]) begin
                if (int'(addr_log[j]) != nw) bad++;
                nw++;
            end
        end
        n_checks++;
        if (nw != 4096 || bad != 0) begin
            n_fail++;
            $display("FAIL sat_writes: writes=%0d addr_errors=%0d, required 4096 and 0", nw, bad);
        end
        n_checks++;
        if (addr_log[4099] !== 12'd4095 || we_log[4099] !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_last: addr=%0d we=%0b, required 4095 1", addr_log[4099], we_log[4099]);
        end
        n_checks++;
        if (done_log[4100] !== 1'b1 || we_log[4100] !== 1'b0 || addr_log[4101] !== '0) begin
            n_fail++;
            $display("FAIL sat_done: done=%0b we=%0b next_addr=%0d, required 1 0 0",
                     done_log[4100], we_log[4100], addr_log[4101]);
        end
    endtask

    task automatic test_timeout;
        int nw, nd;
        trig_mode = 1'b1; trig_level = 13'd8000; cap_len = 13'd16; trig_timeout = 24'd50;
        g_base = 0; g_step = 0; g_neg_at = -1;
        run_ramp(60, -1, 0, -1, -1, -2, -1, -2);
        n_checks++;
        if (busy_log[49] !== 1'b1 || to_log[49] !== 1'b0) begin
            n_fail++;
            $display("FAIL to_before: busy=%0b timed_out=%0b, required 1 0", busy_log[49], to_log[49]);
        end
        n_checks++;
        if (busy_log[50] !== 1'b0 || to_log[50] !== 1'b1 || to_log[59] !== 1'b1) begin
            n_fail++;
            $display("FAIL to_expire: busy=%0b timed_out=%0b sticky=%0b, required 0 1 1",
                     busy_log[50], to_log[50], to_log[59]);
        end
        nw = 0; nd = 0;
        for (int j = 0; j < 60; j++) begin
            nw += int'(we_log[j]);
            nd += int'(done_log[j]);
        end
        n_checks++;
        if (nw != 0 || nd != 0) begin
            n_fail++;
            $display("FAIL to_quiet: writes=%0d dones=%0d, required 0 0", nw, nd);
        end
    endtask

    task automatic test_abort;
        int nw, nd, nb;
        trig_mode = 1'b0; cap_len = 13'd32; trig_timeout = '0;
        g_base = 10; g_step = 5; g_neg_at = -1;
        run_ramp(20, 7, 0, -1, -1, -2, -1, -2);
        n_checks++;
        if (to_log[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_arm_clears_to: timed_out=%0b, required 0", to_log[0]);
        end
        n_checks++;
        if (we_log[6] !== 1'b1 || addr_log[6] !== 12'd5) begin
            n_fail++;
            $display("FAIL abort_sample5: we=%0b addr=%0d, required 1 5", we_log[6], addr_log[6]);
        end
        n_checks++;
        if (we_log[7] !== 1'b0 || busy_log[7] !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_stop: we=%0b busy=%0b, required 0 0", we_log[7], busy_log[7]);
        end
        nw = 0; nd = 0;
        for (int j = 0; j < 20; j++) begin
            nw += int'(we_log[j]);
            nd += int'(done_log[j]);
        end
        n_checks++;
        if (nw != 6 || nd != 0) begin
            n_fail++;
            $display("FAIL abort_counts: writes=%0d dones=%0d, required 6 0", nw, nd);
        end
        // arm and abort together: abort wins, nothing starts
        run_ramp(5, 0, 0, -1, -1, -2, -1, -2);
        nb = 0;
        for (int j = 0; j < 5; j++) nb += int'(busy_log[j]) + int'(we_log[j]);
        n_checks++;
        if (nb != 0) begin
            n_fail++;
            $display("FAIL abort_vs_arm: busy_or_we_cycles=%0d, required 0", nb);
        end
        // re-arm starts at address 0 and runs to completion
        run_ramp(40, -1, 0, -1, -1, -2, -1, -2);
        n_checks++;
        if (we_log[1] !== 1'b1 || addr_log[1] !== '0 || data_log[1] !== {fi(0), fq(0)}) begin
            n_fail++;
            $display("FAIL rearm_first: we=%0b addr=%0d data=%h, required 1 0 %h",
                     we_log[1], addr_log[1], data_log[1], {fi(0), fq(0)});
        end
        n_checks++;
        if (done_log[33] !== 1'b1) begin
            n_fail++;
            $display("FAIL rearm_done: done=%0b, required 1", done_log[33]);
        end
    endtask

    task automatic test_ovr;
        int nw, bad;
        trig_mode = 1'b0; cap_len = 13'd8; trig_timeout = '0;
        g_base = 0; g_step = 1; g_neg_at = -1;
        // or_a on samples 2..4, or_b on 3..4, a stray arm during capture at cycle 4
        run_ramp(14, -1, 0, 4, 2, 4, 3, 4);
        nw = 0; bad = 0;
        for (int j = 0; j < 14; j++) begin
            if (we_log[j]) begin
                if (int'(addr_log[j]) != nw || data_log[j] !== {fi(nw), fq(nw)}) bad++;
                nw++;
            end
        end
        n_checks++;
        if (nw != 8 || bad != 0 || done_log[9] !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_capture: writes=%0d errors=%0d done9=%0b, required 8 0 1", nw, bad, done_log[9]);
        end
        n_checks++;
        if (ovr_count !== 16'd3) begin
            n_fail++;
            $display("FAIL ovr_count: got %0d, required 3", ovr_count);
        end
        run_ramp(1, -1, 0, -1, -1, -2, -1, -2);
        n_checks++;
        if (ovr_count !== 16'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_arm_clear: ovr=%0d busy=%0b, required 0 1", ovr_count, busy);
        end
    endtask

    task automatic test_reset_mid;
        run_ramp(4, -1, -1, -1, 0, 3, -1, -2);
        reset = 1'b1;
        tick;
        n_checks++;
        if ({buf_we, buf_addr, buf_wdata, busy, done, timed_out, ovr_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: we=%0b addr=%0d busy=%0b ovr=%0d, required all zero",
                     buf_we, buf_addr, busy, ovr_count);
        end
        reset = 1'b0;
        tick;
    endtask

    initial begin
        test_reset;
        test_immediate;
        test_threshold;
        test_saturate;
        test_timeout;
        test_abort;
        test_ovr;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
